// File: rtl/cdc_handshake_receiver.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_receiver
// Purpose  : Receiving end of a toggle-handshake clock-domain crossing. A
//            sender in a foreign domain presents a word and flips req_tgl.
//            This block synchronizes the toggle, captures the word into a
//            one-entry output register, flips ack_tgl back to the sender and
//            presents the word downstream with a valid/ready handshake.
//            Every word is delivered exactly once.
// Ports    : clk         - receiving-domain clock (posedge)
//            rst         - asynchronous active-high reset
//            req_tgl     - request toggle from sender (asynchronous)
//            data_in     - sender word, stable from req flip until ack match
//            ack_tgl     - acknowledge toggle, flips once per captured word
//            dout        - captured word
//            dout_valid  - dout holds an undelivered word
//            dout_ready  - downstream accepts dout when dout_valid=1
//            xfer_count  - words delivered downstream (wraps)
//            stalled     - request pending while output register occupied
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_tgl,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   ack_tgl,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic                   stalled
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     seen_q;
  logic                     ack_q;
  logic [DATA_WIDTH-1:0]    dout_q;
  logic [COUNT_WIDTH-1:0]   count_q;

  logic                     req_sync;
  logic                     pending;
  logic                     capture;
  logic                     accept;

  // Request synchronizer: only the toggle crosses through flops; data_in is
  // sampled directly because the sender holds it stable until ack matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign pending  = (req_sync != seen_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control strobes
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (pending) begin
          capture = 1'b1;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (dout_ready) begin
          accept = 1'b1;
          // A pending word refills the register on the same edge the old
          // word leaves, giving back-to-back throughput.
          if (pending) begin
            capture = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Datapath: capture register, acknowledge toggle, consumed-request marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      seen_q <= 1'b0;
      ack_q  <= 1'b0;
    end else if (capture) begin
      dout_q <= data_in;
      seen_q <= req_sync;
      ack_q  <= ~ack_q;
    end
  end

  // Delivered-word counter counts downstream accepts, not captures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign ack_tgl    = ack_q;
  assign dout       = dout_q;
  assign dout_valid = (state_q == ST_FULL);
  assign xfer_count = count_q;
  assign stalled    = (state_q == ST_FULL) && pending && !dout_ready;

endmodule
`default_nettype wire

// File: doc/cdc_handshake_receiver.md
# cdc_handshake_receiver

- Receiving end of the team's toggle-handshake clock-domain crossing.
- A sender in a foreign clock domain presents a data word and flips a request toggle. This block then:
  - synchronizes the request;
  - captures the word into a one-entry output register;
  - returns an acknowledge toggle to the sender;
  - presents the word downstream with a valid/ready handshake.
- Unlike a free-running sampled bridge, every word is delivered exactly once: no skips, no duplicates. It sits in the consuming clock domain, directly behind the asynchronous boundary.

## Interface

Parameters:
- DATA_WIDTH, 8, width of the transferred word.
- SYNC_STAGES, 2, flip-flops in the request synchronizer; legal range 2..4.
- COUNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  receiving-domain clock; every register in the block is clocked on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- req_tgl  input  1  request toggle from the sender domain (asynchronous); each transition announces one new word.
- data_in  input  DATA_WIDTH  sender word (asynchronous); the sender holds it stable from its req_tgl flip until it sees ack_tgl match.
- ack_tgl  output  1  acknowledge toggle to the sender, registered; flips once per captured word.
- dout  output  DATA_WIDTH  captured word.
- dout_valid  output  1  dout holds an undelivered word.
- dout_ready  input  1  downstream accepts dout this cycle when dout_valid=1.
- xfer_count  output  COUNT_WIDTH  number of words delivered downstream; wraps modulo 2^COUNT_WIDTH.
- stalled  output  1  a request is pending but the output register is occupied.

## Operation

Request synchronizer and pending flag:
- req_tgl passes through SYNC_STAGES flops; the last stage is req_sync.
- req_seen holds the req_sync value last consumed.
- pending = (req_sync != req_seen).

State machine (two states):
- EMPTY (dout_valid=0):
  - If pending: dout <= data_in, req_seen <= req_sync, ack_tgl <= ~ack_tgl, dout_valid <= 1, go to FULL.
- FULL (dout_valid=1):
  - If dout_ready: xfer_count <= xfer_count+1.
  - If dout_ready and pending: capture as above in the same cycle (ack flips, dout_valid stays 1, remain FULL). This gives back-to-back throughput.
  - If dout_ready and not pending: dout_valid <= 0, go to EMPTY.
  - If not dout_ready: hold dout, dout_valid, ack_tgl and req_seen unchanged. stalled = pending (combinational from registers).

Capture and handshake rules:
- data_in is sampled only on a capture edge. It is never sampled while pending=0.
- At most one capture per sender toggle. A toggle that arrives while the block is stalled is kept pending; it is neither lost nor acknowledged early.
- ack_tgl flips on exactly the edge where dout is loaded. The sender may therefore change data_in only after dout has been loaded.
- dout stays stable while dout_valid=1 and dout_ready=0.

Other behaviour:
- xfer_count counts downstream accepts, not captures. Wrap: all-ones +1 -> 0.
- The block has no dependence on the sender clock rate. Throughput is bounded by the round trip: sender synchronizing ack_tgl plus this block's SYNC_STAGES.

## Timing

Reset (asynchronous assert; deassertion is synchronized by the system):
- ack_tgl=0, dout=0, dout_valid=0, xfer_count=0, stalled=0.
- Synchronizer flops=0, req_seen=0, state EMPTY.
- Reset asserted mid-transfer: any captured but undelivered word is discarded. The sender must be reset in the same system reset.

Latency:
- req_tgl transition (meeting setup before edge N) to req_sync change: SYNC_STAGES edges.
- dout_valid=1 and ack_tgl flip: 1 edge later, i.e. visible after edge N+SYNC_STAGES.
- Total: SYNC_STAGES+1 clk cycles, ±1 for asynchronous sampling.

Other timing rules:
- Downstream accept: a word handed over on an edge with dout_valid=1 and dout_ready=1 frees the register on that edge.
- Simultaneous accept and pending capture: the new word replaces the old on the same edge. xfer_count increments by exactly 1 and ack_tgl flips by exactly 1.
- stalled is 1 only in state FULL with pending=1 and dout_ready=0.

## Test plan

- Reset state: assert rst mid-cycle -> all outputs 0 immediately; release, hold req_tgl=0 for 20 cycles -> dout_valid stays 0, ack_tgl stays 0.
- Single transfer (SYNC_STAGES=2, dout_ready=1): data_in=0xA5, flip req_tgl 0->1 -> dout=0xA5 with dout_valid=1 and ack_tgl=1 within 3±1 cycles; xfer_count=1 one edge later; dout_valid drops.
- Backpressure: dout_ready=0, deliver 0x11, then the sender flips req with 0x22 -> dout holds 0x11, stalled=1, ack_tgl remains at its first-flip value. Raise dout_ready for 1 cycle -> same edge loads 0x22, ack_tgl flips; xfer_count=1, then 2 after the next accept.
- Stream with a model sender on an unrelated clock (clk 100 MHz, sender 37 MHz) and random dout_ready: 1000 incrementing words -> received in order, no gaps or duplicates; xfer_count=1000 mod 2^16.
- Counter wrap (COUNT_WIDTH=4): 17 transfers -> xfer_count reads 15 then 0 then 1.
- Reset mid-operation: reset while FULL with stalled=1 -> dout_valid=0, ack_tgl=0; after the sender is also reset, the next transfer of 0x5A is delivered exactly once.
